reset_req_responder: RTL

- Synchronous responder for a level reset-request line, such as one driven from a pin or a loop-generated reset source.
- Synchronizes the request and emits a clean, fixed-length, glitch-free reset pulse with no combinational feedback.
- Closes a 4-phase req/ack handshake with the requester.
- Sits between any reset-request source and the logic it resets; replaces feedback-based pulse generation with a counter-driven FSM.

---
 rtl/reset_req_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/reset_req_responder.sv
// Turns a level reset request into a synchronized, fixed-length reset pulse
// and closes a 4-phase req/ack handshake with the requester.
module reset_req_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PULSE_LEN   = 16,
   parameter int unsigned HOLDOFF     = 8,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_i,
   output logic             rst_o,
   output logic             rst_o_n,
   output logic             ack_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] req_count_o
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("reset_req_responder: SYNC_STAGES must be 2..4");
   end
   if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse
      $error("reset_req_responder: PULSE_LEN must be 1..255");
   end
   if (HOLDOFF > 255) begin : g_bad_holdoff
      $error("reset_req_responder: HOLDOFF must be 0..255");
   end

   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
   localparam logic [7:0] HOLD_LOAD  = 8'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ASSERT,
      S_HOLD,
      S_ACK
   } state_t;

   state_t                 state;
   logic [7:0]             cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   req_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], req_i};
      end
   end

   assign req_s = sync[SYNC_STAGES-1];

   // One counter serves both the pulse and the holdoff phase; outputs are
   // registered on the same edge as the state change they belong to.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         rst_o       <= 1'b0;
         rst_o_n     <= 1'b1;
         ack_o       <= 1'b0;
         busy_o      <= 1'b0;
         req_count_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_s) begin
                  state   <= S_ASSERT;
                  cnt     <= PULSE_LOAD;
                  rst_o   <= 1'b1;
                  rst_o_n <= 1'b0;
                  busy_o  <= 1'b1;
               end
            end
            S_ASSERT: begin
               if (cnt == '0) begin
                  rst_o   <= 1'b0;
                  rst_o_n <= 1'b1;
                  if (HOLDOFF == 0) begin
                     state <= S_ACK;
                     ack_o <= 1'b1;
                     if (req_count_o != '1) req_count_o <= req_count_o + 1'b1;
                  end else begin
                     state <= S_HOLD;
                     cnt   <= HOLD_LOAD;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  state <= S_ACK;
                  ack_o <= 1'b1;
                  if (req_count_o != '1) req_count_o <= req_count_o + 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_ACK: begin
               if (!req_s) begin
                  state  <= S_IDLE;
                  ack_o  <= 1'b0;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               rst_o   <= 1'b0;
               rst_o_n <= 1'b1;
               ack_o   <= 1'b0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
